cia_timer: RTL

CIA_TIMER -- requirements
Module: cia_timer

---
 rtl/cia_timer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cia_timer.sv
// CIA-style 16-bit interval timer: latch, down-counter, control register and underflow pulse.
// Define CIA_TIMER_PB_EN to compile in the timer port output (PBON/OUTMODE bits and pb_out).
module cia_timer (
    input  logic       clk_28,
    input  logic       rst,
    input  logic       clk7p_en,
    input  logic       eclk_tick,
    input  logic       cnt_in,
    input  logic       wr,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       underflow,
    output logic       running,
    output logic       pb_out
);

    logic [15:0] latch_q, latch_d;
    logic [15:0] counter_q, counter_d;
    logic        start_q, start_d;
    logic        runMode_q, runMode_d;
    logic        inMode_q, inMode_d;
    logic        underflow_q, underflow_d;
    logic [7:0]  dataOut_q, dataOut_d;

`ifdef CIA_TIMER_PB_EN
    logic        pbOn_q, pbOn_d;
    logic        outMode_q, outMode_d;
    logic        pulse_q, pulse_d;
    logic        toggle_q, toggle_d;
`endif

    logic        countSrc;
    logic        countEvent;
    logic        wrEn;
    logic        loWrite;
    logic        hiWrite;
    logic        crWrite;
    logic        forceLoad;
    logic [15:0] loadValue;
    logic        underflowEvent;
    logic [7:0]  crRead;

    // Counting and register decode; all updates are qualified by the 7 MHz enable.
    always_comb begin
        countSrc       = inMode_q ? cnt_in : eclk_tick;
        countEvent     = clk7p_en & start_q & countSrc;
        wrEn           = wr & clk7p_en;
        loWrite        = wrEn & (addr == 2'd0);
        hiWrite        = wrEn & (addr == 2'd1);
        crWrite        = wrEn & (addr == 2'd2);
        forceLoad      = (hiWrite & ~start_q) | (crWrite & data_in[4]);
        loadValue      = hiWrite ? {data_in, latch_q[7:0]} : latch_q;
        underflowEvent = countEvent & ~forceLoad & (counter_q == 16'd0);
    end

    // Control register as seen on reads; LOAD is a strobe and always reads back 0.
    always_comb begin
        crRead = {2'b00, inMode_q, 1'b0, runMode_q, 2'b00, start_q};
`ifdef CIA_TIMER_PB_EN
        crRead[1] = pbOn_q;
        crRead[2] = outMode_q;
`endif
    end

    always_comb begin
        latch_d     = latch_q;
        counter_d   = counter_q;
        start_d     = start_q;
        runMode_d   = runMode_q;
        inMode_d    = inMode_q;
        underflow_d = underflowEvent;

        if (loWrite) begin
            latch_d[7:0] = data_in;
        end
        if (hiWrite) begin
            latch_d[15:8] = data_in;
        end

        // A load always beats a coincident count event.
        if (forceLoad) begin
            counter_d = loadValue;
        end else if (countEvent) begin
            if (counter_q == 16'd0) begin
                counter_d = latch_q;
            end else begin
                counter_d = counter_q - 16'd1;
            end
        end

        // Register writes override a same-cycle one-shot stop.
        if (underflowEvent && runMode_q) begin
            start_d = 1'b0;
        end
        if (hiWrite && runMode_q) begin
            start_d = 1'b1;
        end
        if (crWrite) begin
            start_d   = data_in[0];
            runMode_d = data_in[3];
            inMode_d  = data_in[5];
        end

        case (addr)
            2'd0:    dataOut_d = counter_q[7:0];
            2'd1:    dataOut_d = counter_q[15:8];
            2'd2:    dataOut_d = crRead;
            default: dataOut_d = 8'h00;
        endcase
    end

`ifdef CIA_TIMER_PB_EN
    // Pulse mode holds for one enable period; toggle mode starts high when the timer starts.
    always_comb begin
        pbOn_d    = pbOn_q;
        outMode_d = outMode_q;
        if (crWrite) begin
            pbOn_d    = data_in[1];
            outMode_d = data_in[2];
        end
        pulse_d  = clk7p_en ? underflowEvent : pulse_q;
        toggle_d = toggle_q;
        if (start_d && !start_q) begin
            toggle_d = 1'b1;
        end else if (underflowEvent) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clk_28) begin
        if (rst) begin
            pbOn_q    <= 1'b0;
            outMode_q <= 1'b0;
            pulse_q   <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            pbOn_q    <= pbOn_d;
            outMode_q <= outMode_d;
            pulse_q   <= pulse_d;
            toggle_q  <= toggle_d;
        end
    end

    assign pb_out = pbOn_q & (outMode_q ? toggle_q : pulse_q);
`else
    assign pb_out = 1'b0;
`endif

    always_ff @(posedge clk_28) begin
        if (rst) begin
            latch_q     <= 16'hFFFF;
            counter_q   <= 16'hFFFF;
            start_q     <= 1'b0;
            runMode_q   <= 1'b0;
            inMode_q    <= 1'b0;
            underflow_q <= 1'b0;
            dataOut_q   <= 8'h00;
        end else begin
            latch_q     <= latch_d;
            counter_q   <= counter_d;
            start_q     <= start_d;
            runMode_q   <= runMode_d;
            inMode_q    <= inMode_d;
            underflow_q <= underflow_d;
            dataOut_q   <= dataOut_d;
        end
    end

    assign data_out  = dataOut_q;
    assign underflow = underflow_q;
    assign running   = start_q;

endmodule
